// File: rtl/eth_fcs_append.sv
// eth_fcs_append: Ethernet TX stage that passes payload bytes through a
// one-deep output register and appends the IEEE 802.3 CRC-32 FCS.
// The CRC register runs MSB-first (poly 0x04C11DB7) on bit-reversed bytes,
// so ~bitrev32(crc) is the standard LSB-first Ethernet FCS.
// Optional feature: define ETH_FCS_PAD_EN to zero-pad short frames up to
// MIN_FRAME bytes, with the pad bytes included in the CRC.
`timescale 1ns/1ps

module eth_fcs_append #(
    parameter int MIN_FRAME = 60
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    input  logic       s_last,
    output logic       s_ready,
    output logic [7:0] m_data,
    output logic       m_valid,
    output logic       m_last,
    input  logic       m_ready
);

    localparam logic [31:0] CRC_POLY = 32'h04C11DB7;
    localparam logic [31:0] CRC_INIT = 32'hFFFFFFFF;

`ifdef ETH_FCS_PAD_EN
    typedef enum logic [1:0] {ST_DATA, ST_PAD, ST_FCS} state_t;
    localparam int CW = $clog2(MIN_FRAME + 2);
    localparam logic [CW-1:0] MIN_C = CW'(MIN_FRAME);
    localparam logic [CW-1:0] ONE_C = CW'(1);
    logic [CW-1:0] count_q, count_d, count_inc;
`else
    typedef enum logic [1:0] {ST_DATA, ST_FCS} state_t;
`endif

    state_t      state_q, state_d;
    logic [31:0] crc_q, crc_d;
    logic [1:0]  fcs_idx_q, fcs_idx_d;
    logic [7:0]  data_d;
    logic        valid_d, last_d;
    logic        slot_free;
    logic [31:0] fcs_word;

    function automatic logic [7:0] bitrev8(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = b[7-i];
        return r;
    endfunction

    function automatic logic [31:0] bitrev32(input logic [31:0] w);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = w[31-i];
        return r;
    endfunction

    // One byte of MSB-first CRC-32; d[7] is the first serial bit.
    function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        logic        fb;
        r = c;
        for (int i = 7; i >= 0; i--) begin
            fb = r[31] ^ d[i];
            r  = {r[30:0], 1'b0};
            if (fb) r = r ^ CRC_POLY;
        end
        return r;
    endfunction

    // The output register can take a new byte when empty or being drained.
    assign slot_free = !m_valid || m_ready;
    assign s_ready   = (state_q == ST_DATA) && slot_free;
    // crc does not move while in FCS, so this is stable for all four bytes.
    assign fcs_word  = ~bitrev32(crc_q);
`ifdef ETH_FCS_PAD_EN
    assign count_inc = count_q + ONE_C;
`endif

    // Next-state and next-output logic; everything holds unless a slot frees.
    always_comb begin
        state_d   = state_q;
        crc_d     = crc_q;
        fcs_idx_d = fcs_idx_q;
        data_d    = m_data;
        valid_d   = m_valid;
        last_d    = m_last;
`ifdef ETH_FCS_PAD_EN
        count_d   = count_q;
`endif
        case (state_q)
            ST_DATA: begin
                if (s_valid && slot_free) begin
                    data_d  = s_data;
                    valid_d = 1'b1;
                    last_d  = 1'b0;
                    crc_d   = crc32_byte(crc_q, bitrev8(s_data));
`ifdef ETH_FCS_PAD_EN
                    count_d = (count_q < MIN_C) ? count_inc : MIN_C;
                    if (s_last) state_d = (count_inc < MIN_C) ? ST_PAD : ST_FCS;
`else
                    if (s_last) state_d = ST_FCS;
`endif
                end else if (slot_free) begin
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                end
            end
`ifdef ETH_FCS_PAD_EN
            ST_PAD: begin
                if (slot_free) begin
                    data_d  = 8'h00;
                    valid_d = 1'b1;
                    last_d  = 1'b0;
                    crc_d   = crc32_byte(crc_q, 8'h00);
                    count_d = count_inc;
                    if (count_inc == MIN_C) state_d = ST_FCS;
                end
            end
`endif
            ST_FCS: begin
                if (slot_free) begin
                    data_d    = fcs_word[{fcs_idx_q, 3'b000} +: 8];
                    valid_d   = 1'b1;
                    last_d    = (fcs_idx_q == 2'd3);
                    fcs_idx_d = fcs_idx_q + 2'd1;
                    if (fcs_idx_q == 2'd3) begin
                        crc_d   = CRC_INIT;
                        state_d = ST_DATA;
`ifdef ETH_FCS_PAD_EN
                        count_d = '0;
`endif
                    end
                end
            end
            default: state_d = ST_DATA;
        endcase
    end

    // State, CRC and output register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_DATA;
            crc_q     <= CRC_INIT;
            fcs_idx_q <= 2'd0;
            m_data    <= 8'h00;
            m_valid   <= 1'b0;
            m_last    <= 1'b0;
`ifdef ETH_FCS_PAD_EN
            count_q   <= '0;
`endif
        end else begin
            state_q   <= state_d;
            crc_q     <= crc_d;
            fcs_idx_q <= fcs_idx_d;
            m_data    <= data_d;
            m_valid   <= valid_d;
            m_last    <= last_d;
`ifdef ETH_FCS_PAD_EN
            count_q   <= count_d;
`endif
        end
    end

endmodule

// File: doc/eth_fcs_append.md
# eth_fcs_append

- Byte-stream Ethernet TX stage that computes the IEEE 802.3 CRC-32 over each outgoing frame and appends the 4-byte FCS after the last payload byte.
- Sits directly upstream of the TX MAC/PHY byte interface. Consumes framed bytes from the packet builder.
- Internally drives the team's big-endian byte CRC update (polynomial 0x04C11DB7, first serial bit D[7]) with bit-reversed input bytes, so the output matches standard Ethernet LSB-first ordering.

## Interface
Parameters:
- MIN_FRAME, 60: minimum payload+pad length in bytes before FCS; used only when padding is compiled in.

Ports:
- clk  in  1  single clock, all logic rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- s_data  in  8  payload byte.
- s_valid  in  1  payload byte valid.
- s_last  in  1  qualifies the final payload byte of a frame.
- s_ready  out  1  stage accepts s_data this cycle.
- m_data  out  8  output byte (payload, pad or FCS).
- m_valid  out  1  output byte valid.
- m_last  out  1  marks the final FCS byte.
- m_ready  in  1  downstream accepts m_data.

## Operation
- States: DATA, PAD, FCS.
- Reset: state=DATA, crc=0xFFFFFFFF, byte count=0, fcs index=0, m_valid=0, m_last=0, m_data=0x00.
- s_ready = (state==DATA) && (!m_valid || m_ready). It is 0 in PAD and FCS.
- Accept in DATA (s_valid && s_ready):
  - Load m_data=s_data, m_valid=1.
  - Update crc with D = bitrev8(s_data).
  - count = min(count+1, MIN_FRAME).
- On an accepted byte with s_last=1:
  - Go to PAD if padding is enabled and count+1 < MIN_FRAME.
  - Otherwise go to FCS.
- PAD: each output slot freed (!m_valid || m_ready) loads m_data=0x00 and updates crc with 0x00. Leave to FCS when count reaches MIN_FRAME.
- FCS:
  - R = ~bitrev32(crc), latched on FCS entry.
  - Send R[7:0], R[15:8], R[23:16], R[31:24] in successive free slots.
  - The 4th byte has m_last=1.
  - After the 4th byte is loaded: crc←0xFFFFFFFF, count←0, state←DATA.
- Output register hold: while m_valid && !m_ready, m_data/m_last hold stable and no state or crc change occurs.
- Back-to-back frames: the first byte of the next frame may be accepted in the cycle the last FCS byte is consumed.
- A 1-byte frame is legal. s_last on a byte with s_valid=0 is ignored.

## Timing
- Payload latency: 1 cycle from s_valid&&s_ready to m_valid.
- FCS byte 0 can appear on m_data the cycle after the last payload or pad byte leaves the register. No bubble occurs under continuous m_ready.
- Throughput: 1 byte/cycle with m_ready held high. Frame of N payload bytes takes N+4 output cycles (max(N,MIN_FRAME)+4 with padding).
- Reset mid-frame: immediate asynchronous return to reset values. The partial frame is discarded with no FCS emitted.

## Configuration
- ETH_FCS_PAD_EN defined:
  - Frames shorter than MIN_FRAME are zero-padded to MIN_FRAME bytes.
  - Pad bytes are included in the CRC.
  - The byte counter and the PAD state are present.
- ETH_FCS_PAD_EN undefined:
  - No PAD state and no counter; FCS follows the last payload byte directly regardless of length.
  - MIN_FRAME is unused.

## Test plan
- Payload ASCII "123456789" (0x31..0x39), m_ready=1, padding disabled -> 9 payload bytes, then 0x26,0x39,0xF4,0xCB with m_last on 0xCB. Output cycle count 13.
- Same 9 bytes, padding enabled -> 9 payload bytes, 51 bytes of 0x00, then the FCS of the 60-byte frame matching a software CRC-32 reference. m_last only on the 64th byte.
- 64-byte incrementing payload 0x00..0x3F, padding enabled -> no pad inserted. FCS equals software CRC-32 of the 64 bytes.
- Random m_ready backpressure (~50%) over two back-to-back frames -> m_data stable while stalled, no byte lost or duplicated, and the second frame's CRC starts from 0xFFFFFFFF (FCS matches its standalone value).
- rst_n pulsed low during byte 5 of a frame, then a fresh "123456789" frame -> outputs go to reset values during reset, and the new frame ends in 0x26,0x39,0xF4,0xCB.
- Single-byte frame 0x00, padding disabled -> 0x00 then 0x8D,0xEF,0x02,0xD2 with m_last on the final byte.
